pager_miss_queue: RTL and testbench
===================================

PAGER_MISS_QUEUE -- requirements
Module: pager_miss_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning queue entries (power of two, 2..8).
REQ-002 SHALL have port clk  input  1  clock, all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have ports dmiss_en, dmiss_inv  input  1 each; dmiss_addr  input  48; dmiss_rdy  output  1: data-TLB miss request.
REQ-005 SHALL have ports imiss_en  input  1; imiss_addr  input  48; imiss_rdy  output  1: code-TLB miss request.
REQ-006 SHALL have ports new_en  output  1; new_can  input  1; new_addr  output  48; new_indir  output  1; new_inv  output  1; new_permReq  output  1: walk request to the pager.
REQ-007 SHALL have port walk_done  input  1, the OR of pager writeTlb_wen, writeTlb_wen_c and writeTlb_wenH_c.
REQ-008 SHALL have ports except  input  1: flush; done_en  output  1; done_addr  output  34 (addr[47:14]); done_code  output  1: replay wakeup.
REQ-009 SHALL have ports merge_cnt  output  16 and busy  output  1.

Function
REQ-010 Queue SHALL be a circular FIFO of DEPTH entries {valid, addr[47:0], inv, code}; head/tail pointers wrap modulo DEPTH; count 0..DEPTH.
REQ-011 Request accepted when en & rdy at a clock edge; source SHALL hold en and addr stable until accepted.
REQ-012 imiss_rdy SHALL be count<DEPTH; dmiss_rdy SHALL be count<DEPTH-1, or count==DEPTH-1 with imiss_en low (code has priority for the last slot).
REQ-013 Both accepted in one cycle: code entry SHALL be written at tail, data entry at tail+1.
REQ-014 FSM states IDLE, WAIT; reset to IDLE.
REQ-015 IDLE: when head valid and new_can high, new_en SHALL be 1 that cycle (combinational), new_* from head entry, new_permReq=code, new_indir=0; next state WAIT.
REQ-016 new_en SHALL be 0 in WAIT, in IDLE with empty queue, and in IDLE with new_can low.
REQ-017 WAIT: on walk_done, SHALL pop head, pulse done_en for 1 cycle (registered, next cycle) with done_addr=head addr[47:14], done_code=head code; next state IDLE.
REQ-018 walk_done in IDLE SHALL be ignored.
REQ-019 Simultaneous push and pop SHALL leave count unchanged; push to a full queue is impossible by REQ-012.
REQ-020 except SHALL invalidate all entries except the in-flight head (WAIT); in IDLE the queue empties; tail resets to head+1 (WAIT) or head (IDLE); done_en for the in-flight head still fires.
REQ-021 except and same-cycle accept: the new request SHALL be dropped, rdy outputs remain as computed.
REQ-022 busy SHALL be 1 when count!=0 or state==WAIT.

Reset
REQ-023 rst SHALL clear all valid bits, head=tail=0, count=0, state=IDLE, merge_cnt=0, done_en=0, done_addr=0, done_code=0.
REQ-024 Outputs after reset: new_en=0, dmiss_rdy=1, imiss_rdy=1, busy=0; new_addr, new_inv, new_permReq, new_indir=0.
REQ-025 rst SHALL override except, walk_done and accepts in the same cycle; rst in WAIT abandons the walk with no done_en.

Configuration
REQ-026 Macro PAGER_MISS_QUEUE_MERGE_EN SHALL enable merging: an accepted request whose addr[47:14] and code equal those of a valid entry not popping this cycle is not enqueued, merge_cnt increments (saturating at 16'hFFFF), rdy unaffected.
REQ-027 Merge SHALL compare against in-flight head too; same-cycle i/d requests never merge (code differs).
REQ-028 Without the macro every accepted request SHALL be enqueued and merge_cnt SHALL be constant 0.

Verification
REQ-029 Reset, then imiss_en addr 48'h0000_1234_4000, new_can=1 -> new_en=1 next edge with new_permReq=1; walk_done 3 cycles later -> done_en=1, done_addr=34'h0_48D1, done_code=1.
REQ-030 Fill DEPTH=4 with new_can=0 -> count 4, imiss_rdy=0, dmiss_rdy=0; count=3 with both en -> only code accepted.
REQ-031 Issue 6 requests through walks -> head/tail wrap, done_en order matches accept order.
REQ-032 With PAGER_MISS_QUEUE_MERGE_EN: two data misses addr 48'h5000 and 48'h5FF8 -> one walk, merge_cnt=1; without macro -> two walks, merge_cnt=0.
REQ-033 3 entries, state WAIT, except pulse -> count=1, walk_done -> done_en once, busy=0 next cycle.
REQ-034 rst asserted in WAIT with walk_done same cycle -> no done_en, state IDLE, all rdy=1.

Source files
------------

// File: rtl/pager_miss_queue.sv
// Circular queue of data/code TLB misses that issues one page-table walk at a time.
// Define PAGER_MISS_QUEUE_MERGE_EN to fold requests for an already queued page into that entry.
module pager_miss_queue #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        dmiss_en,
    input  logic        dmiss_inv,
    input  logic [47:0] dmiss_addr,
    output logic        dmiss_rdy,
    input  logic        imiss_en,
    input  logic [47:0] imiss_addr,
    output logic        imiss_rdy,
    output logic        new_en,
    input  logic        new_can,
    output logic [47:0] new_addr,
    output logic        new_indir,
    output logic        new_inv,
    output logic        new_permReq,
    input  logic        walk_done,
    input  logic        except,
    output logic        done_en,
    output logic [33:0] done_addr,
    output logic        done_code,
    output logic [15:0] merge_cnt,
    output logic        busy
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEPTH - 1);

    typedef enum logic {
        ST_IDLE,
        ST_WAIT
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;

    logic [DEPTH-1:0] valid_q, valid_d;
    logic [47:0]      addr_q [DEPTH];
    logic [DEPTH-1:0] inv_q;
    logic [DEPTH-1:0] code_q;

    logic [DEPTH-1:0] is_head;
    logic [DEPTH-1:0] live;
    logic [DEPTH-1:0] wr_i;
    logic [DEPTH-1:0] wr_d;

    logic        done_en_q;
    logic [33:0] done_addr_q;
    logic        done_code_q;

    logic        head_valid;
    logic [47:0] head_addr;
    logic        pop;
    logic        in_flight;
    logic        i_acc, d_acc;
    logic        i_merge, d_merge;
    logic        i_push, d_push;
    logic [PW-1:0] d_slot;

    assign head_valid = valid_q[head_q];
    assign head_addr  = addr_q[head_q];

    // The code side gets the last free slot when both sources compete for it.
    assign imiss_rdy = (count_q < CNT_FULL);
    assign dmiss_rdy = (count_q < CNT_LAST) || ((count_q == CNT_LAST) && !imiss_en);

    assign i_acc = imiss_en && imiss_rdy;
    assign d_acc = dmiss_en && dmiss_rdy;

    assign pop = (state_q == ST_WAIT) && walk_done;
    // A walk handed to the pager this cycle is already in flight and survives a flush.
    assign in_flight = (state_q == ST_WAIT) || new_en;

    assign i_push = i_acc && !except && !i_merge;
    assign d_push = d_acc && !except && !d_merge;
    assign d_slot = tail_q + PW'(i_push);

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            assign is_head[gi] = (head_q == PW'(gi));
            assign live[gi]    = valid_q[gi] && !(pop && is_head[gi]);
            assign wr_i[gi]    = i_push && (tail_q == PW'(gi));
            assign wr_d[gi]    = d_push && (d_slot == PW'(gi));
            assign valid_d[gi] = except ? (valid_q[gi] && is_head[gi] && in_flight && !pop)
                                        : (live[gi] || wr_i[gi] || wr_d[gi]);
        end
    endgenerate

`ifdef PAGER_MISS_QUEUE_MERGE_EN
    logic [DEPTH-1:0] i_match;
    logic [DEPTH-1:0] d_match;
    logic [15:0]      merge_cnt_q, merge_cnt_d;
    logic [16:0]      merge_sum;

    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_match
            assign i_match[gi] = live[gi] && code_q[gi]
                               && (addr_q[gi][47:14] == imiss_addr[47:14]);
            assign d_match[gi] = live[gi] && !code_q[gi]
                               && (addr_q[gi][47:14] == dmiss_addr[47:14]);
        end
    endgenerate

    assign i_merge = i_acc && !except && (|i_match);
    assign d_merge = d_acc && !except && (|d_match);

    always_comb begin
        merge_sum   = {1'b0, merge_cnt_q} + 17'(i_merge) + 17'(d_merge);
        merge_cnt_d = merge_sum[16] ? 16'hFFFF : merge_sum[15:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            merge_cnt_q <= 16'h0000;
        end else begin
            merge_cnt_q <= merge_cnt_d;
        end
    end

    assign merge_cnt = merge_cnt_q;
`else
    assign i_merge   = 1'b0;
    assign d_merge   = 1'b0;
    assign merge_cnt = 16'h0000;
`endif

    always_comb begin
        state_d = state_q;
        new_en  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (head_valid && new_can) begin
                    new_en  = 1'b1;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (walk_done) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        head_d  = head_q + PW'(pop);
        tail_d  = tail_q + PW'(i_push) + PW'(d_push);
        count_d = count_q + CW'(i_push) + CW'(d_push) - CW'(pop);
        if (except) begin
            if (in_flight) begin
                tail_d  = head_q + PW'(1);
                count_d = pop ? '0 : CW'(1);
            end else begin
                tail_d  = head_q;
                count_d = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            valid_q <= valid_d;
        end
    end

    // Payload needs no reset: every reader qualifies it with the valid bit.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (wr_i[i]) begin
                addr_q[i] <= imiss_addr;
                inv_q[i]  <= 1'b0;
                code_q[i] <= 1'b1;
            end else if (wr_d[i]) begin
                addr_q[i] <= dmiss_addr;
                inv_q[i]  <= dmiss_inv;
                code_q[i] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            done_en_q   <= 1'b0;
            done_addr_q <= '0;
            done_code_q <= 1'b0;
        end else begin
            done_en_q <= pop;
            if (pop) begin
                done_addr_q <= head_addr[47:14];
                done_code_q <= code_q[head_q];
            end
        end
    end

    assign new_addr    = head_valid ? head_addr : '0;
    assign new_inv     = head_valid && inv_q[head_q];
    assign new_permReq = head_valid && code_q[head_q];
    assign new_indir   = 1'b0;

    assign done_en   = done_en_q;
    assign done_addr = done_addr_q;
    assign done_code = done_code_q;

    assign busy = (count_q != '0) || (state_q == ST_WAIT);

endmodule

// File: tb/tb_pager_miss_queue.sv
// Scoreboard bench for pager_miss_queue: expected walks are queued on accept and checked at new_en/done_en.
module tb_pager_miss_queue;
    logic        clk = 1'b0;
    logic        rst;
    logic        dmiss_en, dmiss_inv, imiss_en;
    logic [47:0] dmiss_addr, imiss_addr;
    logic        dmiss_rdy, imiss_rdy;
    logic        new_en, new_can, new_indir, new_inv, new_permReq;
    logic [47:0] new_addr;
    logic        walk_done, except;
    logic        done_en, done_code;
    logic [33:0] done_addr;
    logic [15:0] merge_cnt;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [47:0] addr;
        logic        inv;
        logic        code;
    } exp_t;

    exp_t exp_q[$];

    pager_miss_queue #(.DEPTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .dmiss_en   (dmiss_en),
        .dmiss_inv  (dmiss_inv),
        .dmiss_addr (dmiss_addr),
        .dmiss_rdy  (dmiss_rdy),
        .imiss_en   (imiss_en),
        .imiss_addr (imiss_addr),
        .imiss_rdy  (imiss_rdy),
        .new_en     (new_en),
        .new_can    (new_can),
        .new_addr   (new_addr),
        .new_indir  (new_indir),
        .new_inv    (new_inv),
        .new_permReq(new_permReq),
        .walk_done  (walk_done),
        .except     (except),
        .done_en    (done_en),
        .done_addr  (done_addr),
        .done_code  (done_code),
        .merge_cnt  (merge_cnt),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void sb_push(input logic [47:0] a, input logic inv, input logic code);
        exp_t e;
        e.addr = a;
        e.inv  = inv;
        e.code = code;
        exp_q.push_back(e);
    endfunction

    task automatic idle_inputs();
        dmiss_en = 1'b0; dmiss_inv = 1'b0; dmiss_addr = '0;
        imiss_en = 1'b0; imiss_addr = '0;
        new_can = 1'b0; walk_done = 1'b0; except = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        exp_q.delete();
    endtask

    task automatic push_i(input logic [47:0] a);
        bit ok = 0;
        imiss_en = 1'b1;
        imiss_addr = a;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (imiss_rdy) begin ok = 1; break; end
            tick();
        end
        tick();
        imiss_en = 1'b0;
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL push_i_accept: observed rdy=0 required rdy=1 addr=%h", a);
        end else begin
            sb_push(a, 1'b0, 1'b1);
        end
    endtask

    task automatic push_d(input logic [47:0] a, input logic inv, input bit enq);
        bit ok = 0;
        dmiss_en = 1'b1;
        dmiss_addr = a;
        dmiss_inv = inv;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (dmiss_rdy) begin ok = 1; break; end
            tick();
        end
        tick();
        dmiss_en = 1'b0;
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL push_d_accept: observed rdy=0 required rdy=1 addr=%h", a);
        end else if (enq) begin
            sb_push(a, inv, 1'b0);
        end
    endtask

    // Acts as the pager: accept the walk, finish it lat cycles later, check the wakeup.
    task automatic run_walk(input int lat, input string tag);
        bit   seen = 0;
        exp_t e;
        new_can = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (new_en) begin seen = 1; break; end
            tick();
        end
        checks++;
        if (!seen || exp_q.size() == 0) begin
            failures++;
            $display("FAIL %s_issue: observed new_en=%b required new_en=1 pending=%0d", tag, seen, exp_q.size());
            new_can = 1'b0;
            return;
        end
        e = exp_q[0];
        checks++;
        if (new_addr !== e.addr || new_permReq !== e.code || new_inv !== e.inv || new_indir !== 1'b0) begin
            failures++;
            $display("FAIL %s_req: observed addr=%h perm=%b inv=%b indir=%b required addr=%h perm=%b inv=%b indir=0",
                     tag, new_addr, new_permReq, new_inv, new_indir, e.addr, e.code, e.inv);
        end
        tick();
        checks++;
        if (new_en !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL %s_wait: observed new_en=%b busy=%b required new_en=0 busy=1", tag, new_en, busy);
        end
        repeat (lat - 1) tick();
        walk_done = 1'b1;
        tick();
        walk_done = 1'b0;
        new_can = 1'b0;
        @(negedge clk);
        e = exp_q.pop_front();
        checks++;
        if (done_en !== 1'b1 || done_addr !== e.addr[47:14] || done_code !== e.code) begin
            failures++;
            $display("FAIL %s_done: observed en=%b addr=%h code=%b required en=1 addr=%h code=%b",
                     tag, done_en, done_addr, done_code, e.addr[47:14], e.code);
        end
        $display("walk %s addr=%h code=%b", tag, done_addr, done_code);
        tick();
        checks++;
        if (done_en !== 1'b0) begin
            failures++;
            $display("FAIL %s_pulse: observed done_en=%b required done_en=0", tag, done_en);
        end
    endtask

    task automatic drain(input string tag);
        for (int k = 0; k < 10 && exp_q.size() > 0; k++) run_walk(2 + (k % 3), tag);
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL %s_empty: observed busy=%b required busy=0", tag, busy);
        end
        tick();
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        imiss_en = 1'b1; imiss_addr = 48'h0000_0A00_0000;
        dmiss_en = 1'b1; dmiss_addr = 48'h0000_0B00_0000;
        except = 1'b1; walk_done = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        idle_inputs();
        exp_q.delete();
        @(negedge clk);
        checks++;
        if (new_en !== 1'b0 || dmiss_rdy !== 1'b1 || imiss_rdy !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_ctrl: observed new_en=%b drdy=%b irdy=%b busy=%b required 0 1 1 0",
                     new_en, dmiss_rdy, imiss_rdy, busy);
        end
        checks++;
        if (new_addr !== 48'h0 || new_inv !== 1'b0 || new_permReq !== 1'b0 || new_indir !== 1'b0) begin
            failures++;
            $display("FAIL reset_req: observed addr=%h inv=%b perm=%b indir=%b required all 0",
                     new_addr, new_inv, new_permReq, new_indir);
        end
        checks++;
        if (done_en !== 1'b0 || done_addr !== 34'h0 || done_code !== 1'b0 || merge_cnt !== 16'h0) begin
            failures++;
            $display("FAIL reset_done: observed en=%b addr=%h code=%b merge=%h required all 0",
                     done_en, done_addr, done_code, merge_cnt);
        end
        new_can = 1'b1;
        @(negedge clk);
        checks++;
        if (new_en !== 1'b0) begin
            failures++;
            $display("FAIL reset_empty_issue: observed new_en=%b required new_en=0", new_en);
        end
        new_can = 1'b0;
        tick();
    endtask

    task automatic test_single();
        do_reset();
        new_can = 1'b1;
        push_i(48'h0000_1234_4000);
        checks++;
        if (new_en !== 1'b1 || new_permReq !== 1'b1 || new_addr !== 48'h0000_1234_4000) begin
            failures++;
            $display("FAIL single_issue: observed new_en=%b perm=%b addr=%h required 1 1 000012344000",
                     new_en, new_permReq, new_addr);
        end
        run_walk(3, "single");
    endtask

    task automatic test_fill();
        do_reset();
        push_d(48'h0000_0001_0000, 1'b1, 1'b1);
        push_d(48'h0000_0002_0000, 1'b0, 1'b1);
        push_d(48'h0000_0003_0000, 1'b1, 1'b1);
        @(negedge clk);
        checks++;
        if (dmiss_rdy !== 1'b1 || imiss_rdy !== 1'b1) begin
            failures++;
            $display("FAIL fill_three: observed drdy=%b irdy=%b required 1 1", dmiss_rdy, imiss_rdy);
        end
        tick();
        imiss_en = 1'b1; imiss_addr = 48'h0000_0004_0000;
        dmiss_en = 1'b1; dmiss_addr = 48'h0000_0005_0000; dmiss_inv = 1'b0;
        @(negedge clk);
        checks++;
        if (imiss_rdy !== 1'b1 || dmiss_rdy !== 1'b0) begin
            failures++;
            $display("FAIL fill_last_slot: observed irdy=%b drdy=%b required 1 0", imiss_rdy, dmiss_rdy);
        end
        tick();
        imiss_en = 1'b0;
        dmiss_en = 1'b0;
        sb_push(48'h0000_0004_0000, 1'b0, 1'b1);
        @(negedge clk);
        checks++;
        if (imiss_rdy !== 1'b0 || dmiss_rdy !== 1'b0 || busy !== 1'b1 || new_en !== 1'b0) begin
            failures++;
            $display("FAIL fill_full: observed irdy=%b drdy=%b busy=%b new_en=%b required 0 0 1 0",
                     imiss_rdy, dmiss_rdy, busy, new_en);
        end
        tick();
        walk_done = 1'b1;
        tick();
        walk_done = 1'b0;
        @(negedge clk);
        checks++;
        if (done_en !== 1'b0 || imiss_rdy !== 1'b0) begin
            failures++;
            $display("FAIL idle_walk_done: observed done_en=%b irdy=%b required 0 0", done_en, imiss_rdy);
        end
        tick();
        drain("fill");
    endtask

    task automatic test_back_to_back();
        do_reset();
        imiss_en = 1'b1; imiss_addr = 48'h0000_0100_0000;
        dmiss_en = 1'b1; dmiss_addr = 48'h0000_0200_0000; dmiss_inv = 1'b1;
        @(negedge clk);
        checks++;
        if (imiss_rdy !== 1'b1 || dmiss_rdy !== 1'b1) begin
            failures++;
            $display("FAIL both_rdy: observed irdy=%b drdy=%b required 1 1", imiss_rdy, dmiss_rdy);
        end
        tick();
        imiss_en = 1'b0;
        dmiss_en = 1'b0;
        sb_push(48'h0000_0100_0000, 1'b0, 1'b1);
        sb_push(48'h0000_0200_0000, 1'b1, 1'b0);
        drain("both");
    endtask

    task automatic test_wrap();
        do_reset();
        push_d(48'h0000_1000_0000, 1'b0, 1'b1);
        push_i(48'h0000_2000_0000);
        push_d(48'h0000_3000_0000, 1'b1, 1'b1);
        run_walk(1, "wrap_a");
        run_walk(2, "wrap_b");
        push_i(48'h0000_4000_0000);
        push_d(48'h0000_5000_0000, 1'b0, 1'b1);
        push_i(48'h0000_6000_0000);
        drain("wrap");
    endtask

    task automatic test_merge();
        do_reset();
`ifdef PAGER_MISS_QUEUE_MERGE_EN
        push_d(48'h0000_0000_5000, 1'b0, 1'b1);
        push_d(48'h0000_0000_5FF8, 1'b0, 1'b0);
        @(negedge clk);
        checks++;
        if (merge_cnt !== 16'd1) begin
            failures++;
            $display("FAIL merge_cnt: observed %0d required 1", merge_cnt);
        end
`else
        push_d(48'h0000_0000_5000, 1'b0, 1'b1);
        push_d(48'h0000_0000_5FF8, 1'b0, 1'b1);
        @(negedge clk);
        checks++;
        if (merge_cnt !== 16'd0) begin
            failures++;
            $display("FAIL merge_cnt: observed %0d required 0", merge_cnt);
        end
`endif
        tick();
        drain("merge");
    endtask

    task automatic test_except_wait();
        bit seen = 0;
        do_reset();
        push_d(48'h0000_0700_0000, 1'b0, 1'b1);
        push_d(48'h0000_0800_0000, 1'b0, 1'b1);
        push_i(48'h0000_0900_0000);
        new_can = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (new_en) begin seen = 1; break; end
            tick();
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL except_issue: observed new_en=0 required new_en=1");
        end
        tick();
        new_can = 1'b0;
        except = 1'b1;
        tick();
        except = 1'b0;
        while (exp_q.size() > 1) void'(exp_q.pop_back());
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || done_en !== 1'b0) begin
            failures++;
            $display("FAIL except_keep: observed busy=%b done_en=%b required 1 0", busy, done_en);
        end
        tick();
        walk_done = 1'b1;
        tick();
        walk_done = 1'b0;
        @(negedge clk);
        checks++;
        if (done_en !== 1'b1 || done_addr !== exp_q[0].addr[47:14] || busy !== 1'b0) begin
            failures++;
            $display("FAIL except_done: observed en=%b addr=%h busy=%b required en=1 addr=%h busy=0",
                     done_en, done_addr, busy, exp_q[0].addr[47:14]);
        end
        $display("walk except addr=%h code=%b", done_addr, done_code);
        exp_q.delete();
        tick();
        new_can = 1'b1;
        @(negedge clk);
        checks++;
        if (done_en !== 1'b0 || new_en !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL except_flushed: observed done_en=%b new_en=%b busy=%b required 0 0 0",
                     done_en, new_en, busy);
        end
        new_can = 1'b0;
        tick();
    endtask

    task automatic test_except_idle();
        do_reset();
        push_d(48'h0000_0C00_0000, 1'b0, 1'b1);
        push_d(48'h0000_0D00_0000, 1'b0, 1'b1);
        except = 1'b1;
        imiss_en = 1'b1; imiss_addr = 48'h0000_0E00_0000;
        @(negedge clk);
        checks++;
        if (imiss_rdy !== 1'b1) begin
            failures++;
            $display("FAIL except_accept_rdy: observed irdy=%b required 1", imiss_rdy);
        end
        tick();
        except = 1'b0;
        imiss_en = 1'b0;
        exp_q.delete();
        new_can = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || new_en !== 1'b0) begin
            failures++;
            $display("FAIL except_idle_empty: observed busy=%b new_en=%b required 0 0", busy, new_en);
        end
        tick();
        new_can = 1'b0;
        push_i(48'h0000_0F00_0000);
        drain("after_except");
    endtask

    task automatic test_rst_in_wait();
        bit seen = 0;
        do_reset();
        push_i(48'h0000_0AB0_0000);
        new_can = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (new_en) begin seen = 1; break; end
            tick();
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL rst_wait_issue: observed new_en=0 required new_en=1");
        end
        tick();
        new_can = 1'b0;
        rst = 1'b1;
        walk_done = 1'b1;
        tick();
        rst = 1'b0;
        walk_done = 1'b0;
        exp_q.delete();
        @(negedge clk);
        checks++;
        if (done_en !== 1'b0 || busy !== 1'b0 || imiss_rdy !== 1'b1 || dmiss_rdy !== 1'b1 || new_en !== 1'b0) begin
            failures++;
            $display("FAIL rst_wait: observed done_en=%b busy=%b irdy=%b drdy=%b new_en=%b required 0 0 1 1 0",
                     done_en, busy, imiss_rdy, dmiss_rdy, new_en);
        end
        tick();
        @(negedge clk);
        checks++;
        if (done_en !== 1'b0) begin
            failures++;
            $display("FAIL rst_wait_late: observed done_en=%b required 0", done_en);
        end
        tick();
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_single();
        test_fill();
        test_back_to_back();
        test_wrap();
        test_merge();
        test_except_wait();
        test_except_idle();
        test_rst_in_wait();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
